kfx86_multiply_sequencer: RTL and testbench

Multi-cycle controller that runs unsigned MUL (byte and word) on the shared x86 ALU/accumulator datapath using shift-and-add. Each iteration it drives the ALU's ADD opcode and operands, captures the ALU sum and carry, and shifts a product register pair. It sits beside the ALU in the execution unit and owns the ALU inputs only while busy; the execution unit muxes them in when alu_grant is high.

---
 rtl/kfx86_multiply_sequencer.sv | 165 ++++++++++++++++
 tb/tb_kfx86_multiply_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kfx86_multiply_sequencer.sv
// Shift-and-add sequencer for unsigned MUL (8x8 and 16x16) that borrows the shared ALU while busy.
// Optional macro KFX86_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain, using a barrel shift.
module kfx86_multiply_sequencer #(
    parameter logic [4:0] ALU_OP_ADD = 5'b00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        select_word,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        cf_of,
    output logic        alu_grant,
    output logic [4:0]  alu_opcode,
    output logic [15:0] alu_source_1,
    output logic [15:0] alu_source_2,
    output logic        alu_select_word,
    input  logic [15:0] alu_out,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [15:0] l_q, l_d;
    logic [15:0] a_q, a_d;
    logic        w_q, w_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] product_q, product_d;
    logic        cf_of_q, cf_of_d;

    // Iteration datapath, evaluated every cycle and consumed only in ITER.
    logic        bit_c;
    logic [15:0] sum;
    logic [15:0] h_shift, l_shift;
    logic [15:0] h_fin, l_fin;
    logic        last_iter;
    logic        iter_finish;

`ifdef KFX86_MUL_EARLY_EXIT_EN
    logic [15:0] rem_mask;
    logic        early_exit;
    logic [4:0]  shift_amt;
    logic [31:0] wide_shift;
    logic [15:0] narrow_shift;
`endif

    // NOTE: every signal written in this block gets a value on every path, so no latch is inferred.
    always_comb begin
        bit_c     = l_q[0] & alu_carry;
        sum       = l_q[0] ? alu_out : h_q;
        if (w_q) begin
            h_shift = {bit_c, sum[15:1]};
            l_shift = {sum[0], l_q[15:1]};
        end else begin
            h_shift = {8'h00, bit_c, sum[7:1]};
            l_shift = {8'h00, sum[0], l_q[7:1]};
        end
        last_iter = (count_q == (w_q ? 4'd15 : 4'd7));

`ifdef KFX86_MUL_EARLY_EXIT_EN
        // Bits below the mask are multiplier bits not yet consumed after this shift.
        rem_mask     = (w_q ? 16'hFFFF : 16'h00FF) >> ({1'b0, count_q} + 5'd1);
        early_exit   = ~|(l_shift & rem_mask);
        shift_amt    = (w_q ? 5'd15 : 5'd7) - {1'b0, count_q};
        wide_shift   = {h_shift, l_shift} >> shift_amt;
        narrow_shift = {h_shift[7:0], l_shift[7:0]} >> shift_amt;
        if (early_exit) begin
            h_fin = w_q ? wide_shift[31:16] : {8'h00, narrow_shift[15:8]};
            l_fin = w_q ? wide_shift[15:0]  : {8'h00, narrow_shift[7:0]};
        end else begin
            h_fin = h_shift;
            l_fin = l_shift;
        end
        iter_finish = early_exit | last_iter;
`else
        h_fin       = h_shift;
        l_fin       = l_shift;
        iter_finish = last_iter;
`endif
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        l_d       = l_q;
        a_d       = a_q;
        w_d       = w_q;
        count_d   = count_q;
        product_d = product_q;
        cf_of_d   = cf_of_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = select_word ? multiplicand : {8'h00, multiplicand[7:0]};
                    l_d     = select_word ? multiplier   : {8'h00, multiplier[7:0]};
                    h_d     = 16'h0000;
                    w_d     = select_word;
                    count_d = 4'd0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                h_d     = h_fin;
                l_d     = l_fin;
                count_d = count_q + 4'd1;
                if (iter_finish) begin
                    state_d   = ST_DONE;
                    product_d = w_q ? {h_fin, l_fin} : {16'h0000, h_fin[7:0], l_fin[7:0]};
                    cf_of_d   = w_q ? |h_fin : |h_fin[7:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all registers here are plain flops (no memory array), so each one is cleared on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            h_q       <= 16'h0000;
            l_q       <= 16'h0000;
            a_q       <= 16'h0000;
            w_q       <= 1'b0;
            count_q   <= 4'd0;
            product_q <= 32'h0000_0000;
            cf_of_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            l_q       <= l_d;
            a_q       <= a_d;
            w_q       <= w_d;
            count_q   <= count_d;
            product_q <= product_d;
            cf_of_q   <= cf_of_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign alu_grant       = (state_q == ST_ITER);
    assign alu_opcode      = alu_grant ? ALU_OP_ADD : 5'b00000;
    assign alu_source_1    = h_q;
    assign alu_source_2    = a_q;
    assign alu_select_word = w_q;
    assign product         = product_q;
    assign cf_of           = cf_of_q;

endmodule

// File: tb/tb_kfx86_multiply_sequencer.sv
// Directed bench for kfx86_multiply_sequencer with a behavioural ALU; latency expectations follow KFX86_MUL_EARLY_EXIT_EN.
module tb_kfx86_multiply_sequencer;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        select_word;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        cf_of;
    logic        alu_grant;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_source_1;
    logic [15:0] alu_source_2;
    logic        alu_select_word;
    logic [15:0] alu_out;
    logic        alu_carry;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    kfx86_multiply_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .select_word     (select_word),
        .multiplicand    (multiplicand),
        .multiplier      (multiplier),
        .busy            (busy),
        .done            (done),
        .product         (product),
        .cf_of           (cf_of),
        .alu_grant       (alu_grant),
        .alu_opcode      (alu_opcode),
        .alu_source_1    (alu_source_1),
        .alu_source_2    (alu_source_2),
        .alu_select_word (alu_select_word),
        .alu_out         (alu_out),
        .alu_carry       (alu_carry)
    );

    // Behavioural ALU: ADD per width; any other opcode yields XOR so a wrong opcode corrupts results.
    logic [16:0] alu_sum_w;
    logic [8:0]  alu_sum_b;
    assign alu_sum_w = {1'b0, alu_source_1} + {1'b0, alu_source_2};
    assign alu_sum_b = {1'b0, alu_source_1[7:0]} + {1'b0, alu_source_2[7:0]};
    assign alu_out   = (alu_opcode != ALU_OP_ADD) ? (alu_source_1 ^ alu_source_2) :
                       alu_select_word ? alu_sum_w[15:0] : {alu_source_1[15:8], alu_sum_b[7:0]};
    assign alu_carry = (alu_opcode != ALU_OP_ADD) ? 1'b0 :
                       alu_select_word ? alu_sum_w[16] : alu_sum_b[8];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts an operation and waits for done; cycles are counted in edges, the sampling edge being 1.
    task automatic run_mul(input string tag, input logic w, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_p, input logic exp_cf, input int exp_cyc);
        int cyc;
        int bad_op;
        int grant_cyc;
        select_word  = w;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 16'h5A5A;
        multiplier   = 16'hA5A5;
        select_word  = ~w;
        cyc          = 1;
        bad_op       = 0;
        grant_cyc    = 0;
        while (!done && cyc < 40) begin
            if (alu_grant) begin
                grant_cyc++;
                if (alu_opcode !== ALU_OP_ADD) bad_op++;
            end
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " product"}, product, exp_p);
        check({tag, " cf_of"}, {31'd0, cf_of}, {31'd0, exp_cf});
        check({tag, " opcode"}, bad_op, 0);
        check({tag, " grant_cycles"}, grant_cyc, exp_cyc - 1);
        tick();
        check({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, " hold"}, product, exp_p);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        reset        = 1'b1;
        start        = 1'b0;
        select_word  = 1'b0;
        multiplicand = 16'h0000;
        multiplier   = 16'h0000;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", product, 32'd0);
        check("reset cf_of", {31'd0, cf_of}, 32'd0);
        check("reset grant", {31'd0, alu_grant}, 32'd0);
        check("reset opcode", {27'd0, alu_opcode}, 32'd0);
        reset = 1'b0;
        tick();

`ifdef KFX86_MUL_EARLY_EXIT_EN
        run_mul("b_ff_ff",     1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1, 9);
        run_mul("w_1234_10",   1'b1, 16'h1234, 16'h0010, 32'h0001_2340, 1'b1, 6);
        run_mul("w_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 17);
        run_mul("b_12_03",     1'b0, 16'h0012, 16'h0003, 32'h0000_0036, 1'b0, 3);
        run_mul("b_masked",    1'b0, 16'hAB12, 16'hCD03, 32'h0000_0036, 1'b0, 3);
        run_mul("w_0_beef",    1'b1, 16'h0000, 16'hBEEF, 32'h0000_0000, 1'b0, 17);
        run_mul("b_03_02",     1'b0, 16'h0003, 16'h0002, 32'h0000_0006, 1'b0, 3);
        run_mul("b_03_00",     1'b0, 16'h0003, 16'h0000, 32'h0000_0000, 1'b0, 2);
        run_mul("b_03_80",     1'b0, 16'h0003, 16'h0080, 32'h0000_0180, 1'b1, 9);
`else
        run_mul("b_ff_ff",     1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1, 9);
        run_mul("w_1234_10",   1'b1, 16'h1234, 16'h0010, 32'h0001_2340, 1'b1, 17);
        run_mul("w_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 17);
        run_mul("b_12_03",     1'b0, 16'h0012, 16'h0003, 32'h0000_0036, 1'b0, 9);
        run_mul("b_masked",    1'b0, 16'hAB12, 16'hCD03, 32'h0000_0036, 1'b0, 9);
        run_mul("w_0_beef",    1'b1, 16'h0000, 16'hBEEF, 32'h0000_0000, 1'b0, 17);
        run_mul("b_03_02",     1'b0, 16'h0003, 16'h0002, 32'h0000_0006, 1'b0, 9);
        run_mul("b_03_00",     1'b0, 16'h0003, 16'h0000, 32'h0000_0000, 1'b0, 9);
        run_mul("b_03_80",     1'b0, 16'h0003, 16'h0080, 32'h0000_0180, 1'b1, 9);
`endif

        // Restarts while busy and during DONE must be dropped.
        select_word  = 1'b1;
        multiplicand = 16'h1234;
        multiplier   = 16'h0010;
        start        = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        done_cnt = 0;
        while (!done && cyc < 40) begin
            if (cyc == 3) begin
                start        = 1'b1;
                multiplicand = 16'h00FF;
                multiplier   = 16'h00FF;
                select_word  = 1'b0;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
`ifdef KFX86_MUL_EARLY_EXIT_EN
        check("ign latency", cyc, 6);
`else
        check("ign latency", cyc, 17);
`endif
        check("ign product", product, 32'h0001_2340);
        start        = 1'b1;
        multiplicand = 16'h0005;
        multiplier   = 16'h0007;
        select_word  = 1'b0;
        tick();
        start = 1'b0;
        check("ign done_start busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("ign no second done", done_cnt, 0);
        check("ign product kept", product, 32'h0001_2340);

        // Asynchronous reset in the middle of an iteration run.
        select_word  = 1'b1;
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid busy before reset", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async busy", {31'd0, busy}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        check("async product", product, 32'd0);
        check("async grant", {31'd0, alu_grant}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
`ifdef KFX86_MUL_EARLY_EXIT_EN
        run_mul("b_7_6", 1'b0, 16'h0007, 16'h0006, 32'h0000_002A, 1'b0, 4);
`else
        run_mul("b_7_6", 1'b0, 16'h0007, 16'h0006, 32'h0000_002A, 1'b0, 9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
